subneg_loader: RTL

Upstream program loader for the subneg CPU. Accepts 5-bit words from slow external pins using a strobe handshake and writes them sequentially into the CPU's memory write port. While loading, the loader holds the CPU stopped; when loading ends it issues a one-cycle restart so the CPU starts fresh from PC 0. The CPU's datapath is unchanged; the top level muxes the loader's write port onto the memory array.

---
 rtl/subneg_loader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/subneg_loader.sv
// Program loader for the subneg CPU: synchronises a slow strobe/data pin interface,
// writes words sequentially into memory and holds/restarts the CPU around the load.
module subneg_loader #(
   parameter int unsigned WORD_W = 5,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 22
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              load_req_i,
   input  logic              strb_i,
   input  logic [WORD_W-1:0] din_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [WORD_W-1:0] mem_wdata_o,
   output logic              cpu_run_o,
   output logic              cpu_restart_o,
   output logic [7:0]        status_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    count_q;
   logic                overflow_q;

   logic                lr_s1_q, lr_s2_q, lr_s3_q;
   logic                st_s1_q, st_s2_q, st_s3_q;
   logic [WORD_W-1:0]   din_s1_q, din_s2_q;

   logic                strb_ev;
   logic                lr_rise;
   logic                lr_fall;
   logic                last_word;
   logic                room;

   assign strb_ev   = st_s2_q & ~st_s3_q;
   assign lr_rise   = lr_s2_q & ~lr_s3_q;
   assign lr_fall   = ~lr_s2_q & lr_s3_q;
   assign last_word = (count_q == CNT_W'(DEPTH - 1));
   assign room      = (count_q < CNT_W'(DEPTH));

   // status is a plain concatenation of registers, so it carries no input-to-output path
   assign status_o = {state_q, overflow_q, 5'(count_q)};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= ST_RUN;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         mem_we_o      <= 1'b0;
         mem_addr_o    <= '0;
         mem_wdata_o   <= '0;
         cpu_run_o     <= 1'b1;
         cpu_restart_o <= 1'b0;
         lr_s1_q       <= 1'b0;
         lr_s2_q       <= 1'b0;
         lr_s3_q       <= 1'b0;
         st_s1_q       <= 1'b0;
         st_s2_q       <= 1'b0;
         st_s3_q       <= 1'b0;
         din_s1_q      <= '0;
         din_s2_q      <= '0;
      end else begin
         lr_s1_q  <= load_req_i;
         lr_s2_q  <= lr_s1_q;
         lr_s3_q  <= lr_s2_q;
         st_s1_q  <= strb_i;
         st_s2_q  <= st_s1_q;
         st_s3_q  <= st_s2_q;
         din_s1_q <= din_i;
         din_s2_q <= din_s1_q;

         mem_we_o      <= 1'b0;
         cpu_restart_o <= 1'b0;

         case (state_q)
            ST_RUN: begin
               cpu_run_o <= 1'b1;
               if (lr_rise) begin
                  state_q    <= ST_LOAD;
                  cpu_run_o  <= 1'b0;
                  count_q    <= '0;
                  overflow_q <= 1'b0;
               end
            end
            ST_LOAD: begin
               cpu_run_o <= 1'b0;
               if (strb_ev && room) begin
                  mem_we_o    <= 1'b1;
                  mem_addr_o  <= ADDR_W'(count_q);
                  mem_wdata_o <= din_s2_q;
                  count_q     <= count_q + CNT_W'(1);
               end
               // a coincident strobe is written above before leaving
               if (lr_fall || (strb_ev && last_word)) begin
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               cpu_run_o     <= 1'b0;
               cpu_restart_o <= 1'b1;
               state_q       <= ST_RUN;
               if (strb_ev) begin
                  overflow_q <= 1'b1;
               end
            end
            default: begin
               state_q   <= ST_RUN;
               cpu_run_o <= 1'b1;
            end
         endcase
      end
   end

endmodule
